// File: rtl/usr_sequencer.sv
// rtl/usr_sequencer.sv - command sequencer driving a 4-bit universal shift register
module usr_sequencer (
  input  logic       clk_21,
  input  logic       rst_21,
  input  logic       cmd_valid_21,
  output logic       cmd_ready_21,
  input  logic [2:0] cmd_op_21,
  input  logic [2:0] cmd_cnt_21,
  input  logic [3:0] cmd_data_21,
  input  logic       cmd_fill_21,
  input  logic       stall_21,
  input  logic [3:0] dout_21,
  input  logic       MSBout_21,
  input  logic       LSBout_21,
  output logic       s1_21,
  output logic       s0_21,
  output logic [3:0] din_21,
  output logic       MSBin_21,
  output logic       LSBin_21,
  output logic       done_21,
  output logic [3:0] result_21,
  output logic [7:0] spill_21
);

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_SETTLE} state_t;

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic [2:0] cnt_q;
  logic [3:0] data_q;
  logic       fill_q;

  logic accept;
  logic in_load, in_shift;
  logic q_shifts, q_left;
  logic shift_edge;

  assign cmd_ready_21 = (state == ST_IDLE);
  assign accept       = cmd_valid_21 & cmd_ready_21;
  assign in_load      = (cmd_op_21 == OP_LOAD) | (cmd_op_21[2:1] == 2'b11);
  assign in_shift     = cmd_op_21[2] | cmd_op_21[1];
  assign q_shifts     = op_q[2] | op_q[1];
  // Odd opcodes among the shifting ops move data toward bit 3.
  assign q_left       = op_q[0];
  assign shift_edge   = (state == ST_SHIFT) & ~stall_21;
  assign din_21       = data_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (in_load)                             state_nxt = ST_LOAD;
          else if (in_shift && cmd_cnt_21 != 3'd0) state_nxt = ST_SHIFT;
          else                                     state_nxt = ST_SETTLE;
        end
      end
      ST_LOAD: begin
        if (!stall_21)
          state_nxt = (q_shifts && cnt_q != 3'd0) ? ST_SHIFT : ST_SETTLE;
      end
      ST_SHIFT: begin
        if (!stall_21 && cnt_q == 3'd1) state_nxt = ST_SETTLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s1_21    = 1'b0;
    s0_21    = 1'b0;
    MSBin_21 = 1'b0;
    LSBin_21 = 1'b0;
    if (state == ST_LOAD && !stall_21) begin
      s1_21 = 1'b1;
      s0_21 = 1'b1;
    end
    if (state == ST_SHIFT) begin
      if (!stall_21) begin
        s1_21 = q_left;
        s0_21 = ~q_left;
      end
      if (op_q == OP_ROR) begin
        MSBin_21 = LSBout_21;
      end else if (op_q == OP_ROL) begin
        LSBin_21 = MSBout_21;
      end else begin
        MSBin_21 = fill_q;
        LSBin_21 = fill_q;
      end
    end
  end

  always_ff @(posedge clk_21 or negedge rst_21) begin
    if (!rst_21) begin
      state     <= ST_IDLE;
      op_q      <= 3'd0;
      cnt_q     <= 3'd0;
      data_q    <= 4'd0;
      fill_q    <= 1'b0;
      spill_21  <= 8'd0;
      done_21   <= 1'b0;
      result_21 <= 4'd0;
    end else begin
      state   <= state_nxt;
      done_21 <= (state == ST_SETTLE);
      if (state == ST_SETTLE) result_21 <= dout_21;
      if (accept) begin
        op_q     <= cmd_op_21;
        cnt_q    <= cmd_cnt_21;
        data_q   <= cmd_data_21;
        fill_q   <= cmd_fill_21;
        spill_21 <= 8'd0;
      end
      if (shift_edge) begin
        cnt_q    <= cnt_q - 3'd1;
        spill_21 <= {spill_21[6:0], q_left ? MSBout_21 : LSBout_21};
      end
    end
  end

endmodule

// File: tb/tb_usr_sequencer.sv
// tb/tb_usr_sequencer.sv - scoreboard bench for usr_sequencer with a behavioural USR
module tb_usr_sequencer;

  logic       clk_21 = 1'b0;
  logic       rst_21;
  logic       cmd_valid_21;
  logic       cmd_ready_21;
  logic [2:0] cmd_op_21;
  logic [2:0] cmd_cnt_21;
  logic [3:0] cmd_data_21;
  logic       cmd_fill_21;
  logic       stall_21;
  logic [3:0] dout_21;
  logic       MSBout_21, LSBout_21;
  logic       s1_21, s0_21;
  logic [3:0] din_21;
  logic       MSBin_21, LSBin_21;
  logic       done_21;
  logic [3:0] result_21;
  logic [7:0] spill_21;

  usr_sequencer dut (
    .clk_21(clk_21), .rst_21(rst_21),
    .cmd_valid_21(cmd_valid_21), .cmd_ready_21(cmd_ready_21),
    .cmd_op_21(cmd_op_21), .cmd_cnt_21(cmd_cnt_21),
    .cmd_data_21(cmd_data_21), .cmd_fill_21(cmd_fill_21),
    .stall_21(stall_21), .dout_21(dout_21),
    .MSBout_21(MSBout_21), .LSBout_21(LSBout_21),
    .s1_21(s1_21), .s0_21(s0_21), .din_21(din_21),
    .MSBin_21(MSBin_21), .LSBin_21(LSBin_21),
    .done_21(done_21), .result_21(result_21), .spill_21(spill_21)
  );

  always #5 clk_21 = ~clk_21;

  // Behavioural universal shift register closing the loop.
  logic [3:0] usr_q = 4'd0;
  always @(posedge clk_21) begin
    case ({s1_21, s0_21})
      2'b01:   usr_q <= {MSBin_21, usr_q[3:1]};
      2'b10:   usr_q <= {usr_q[2:0], LSBin_21};
      2'b11:   usr_q <= din_21;
      default: usr_q <= usr_q;
    endcase
  end
  assign dout_21   = usr_q;
  assign MSBout_21 = usr_q[3];
  assign LSBout_21 = usr_q[0];

  int cyc = 0;
  always @(posedge clk_21) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] res;
    logic [7:0] spill;
    int         done_cyc;
    bit         quiet;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mode_seen = 0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_21) begin
    if (!rst_21) begin
      mode_seen = 0;
    end else begin
      if (s1_21 | s0_21) mode_seen = 1;
      if (done_21) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("result", result_21, mon_e.res);
          chk("spill", spill_21, mon_e.spill);
          chk("done_cycle", cyc, mon_e.done_cyc);
          if (mon_e.quiet) chk("usr_untouched", mode_seen, 0);
        end
        mode_seen = 0;
      end
    end
  end

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic issue(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data,
                       input logic fill, input logic [3:0] res, input logic [7:0] sp,
                       input int lat, input bit quiet, output int acc);
    exp_t e;
    int   wt = 0;
    cmd_valid_21 = 1'b1;
    cmd_op_21    = op;
    cmd_cnt_21   = cnt;
    cmd_data_21  = data;
    cmd_fill_21  = fill;
    acc = -1;
    while (!cmd_ready_21 && wt < 50) begin
      @(negedge clk_21);
      wt++;
    end
    if (!cmd_ready_21) begin
      chk("accept_timeout", 1, 0);
      cmd_valid_21 = 1'b0;
      return;
    end
    @(posedge clk_21);
    #1;
    acc        = cyc;
    e.res      = res;
    e.spill    = sp;
    e.done_cyc = cyc + lat;
    e.quiet    = quiet;
    sb.push_back(e);
    @(negedge clk_21);
    cmd_valid_21 = 1'b0;
    cmd_op_21    = 3'b111;
    cmd_cnt_21   = 3'd7;
    cmd_data_21  = 4'hF;
  endtask

  task automatic wait_idle();
    int wt = 0;
    while (sb.size() != 0 && wt < 60) begin
      @(posedge clk_21);
      wt++;
    end
    if (sb.size() != 0) chk("done_timeout", 1, 0);
    @(negedge clk_21);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, cmd_ready_21, 1);
    chk({tag, "_mode"}, {s1_21, s0_21}, 0);
    chk({tag, "_din"}, din_21, 0);
    chk({tag, "_serial"}, {MSBin_21, LSBin_21}, 0);
    chk({tag, "_done"}, done_21, 0);
    chk({tag, "_result"}, result_21, 0);
    chk({tag, "_spill"}, spill_21, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, done_c, wt;
    rst_21 = 1'b0;
    cmd_valid_21 = 1'b0;
    cmd_op_21 = 3'd0;
    cmd_cnt_21 = 3'd0;
    cmd_data_21 = 4'd0;
    cmd_fill_21 = 1'b0;
    stall_21 = 1'b0;
    repeat (2) @(negedge clk_21);
    chk_reset_outputs("rst0");
    rst_21 = 1'b1;
    @(negedge clk_21);

    // LOAD_SHR 1011 cnt2 fill0: 1011 -> 0101 -> 0010
    issue(3'b110, 3'd2, 4'b1011, 1'b0, 4'b0010, 8'b0000_0011, 4, 0, acc);
    wait_idle();
    // SHL cnt3 fill1 on 0010: 0101, 1011, 0111
    issue(3'b011, 3'd3, 4'b0000, 1'b1, 4'b0111, 8'b0000_0001, 4, 0, acc);
    wait_idle();
    // LOAD ignores the count
    issue(3'b001, 3'd5, 4'b1001, 1'b0, 4'b1001, 8'h00, 2, 0, acc);
    wait_idle();
    issue(3'b101, 3'd1, 4'b0000, 1'b0, 4'b0011, 8'b0000_0001, 2, 0, acc);
    wait_idle();
    issue(3'b001, 3'd0, 4'b1001, 1'b0, 4'b1001, 8'h00, 2, 0, acc);
    wait_idle();
    // ROR x4 returns to 1001; spilled LSBs 1,0,0,1
    issue(3'b100, 3'd4, 4'b0000, 1'b0, 4'b1001, 8'b0000_1001, 5, 0, acc);
    wait_idle();
    issue(3'b000, 3'd3, 4'b0110, 1'b1, 4'b1001, 8'h00, 1, 1, acc);
    wait_idle();
    issue(3'b010, 3'd0, 4'b0110, 1'b1, 4'b1001, 8'h00, 1, 1, acc);
    wait_idle();

    // LOAD_SHL 0001 cnt3 with a two-cycle stall in SHIFT
    issue(3'b111, 3'd3, 4'b0001, 1'b0, 4'b1000, 8'h00, 7, 0, acc);
    @(negedge clk_21);
    stall_21 = 1'b1;
    #1 chk("stall_mode_a", {s1_21, s0_21}, 0);
    @(negedge clk_21);
    #1 chk("stall_mode_b", {s1_21, s0_21}, 0);
    @(negedge clk_21);
    stall_21 = 1'b0;
    wt = 0;
    while (!done_21 && wt < 20) begin
      @(negedge clk_21);
      wt++;
    end
    chk("stall_done_seen", done_21, 1);
    done_c = cyc;
    // presented during the done cycle: SHR cnt2 fill1 on 1000 -> 1100 -> 1110
    issue(3'b010, 3'd2, 4'b0000, 1'b1, 4'b1110, 8'h00, 3, 0, acc);
    chk("b2b_accept_cycle", acc, done_c + 1);
    wait_idle();

    // Reset in the middle of a long shift
    issue(3'b010, 3'd7, 4'b0000, 1'b1, 4'b0000, 8'h00, 8, 0, acc);
    repeat (2) @(negedge clk_21);
    #2 rst_21 = 1'b0;
    sb.delete();
    #1 chk_reset_outputs("rst_mid");
    @(negedge clk_21);
    @(negedge clk_21);
    rst_21 = 1'b1;
    #1 chk("ready_after_rst", cmd_ready_21, 1);
    @(negedge clk_21);
    issue(3'b001, 3'd0, 4'b0110, 1'b0, 4'b0110, 8'h00, 2, 0, acc);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
